out_byte_sequencer: RTL and testbench

OUT_BYTE_SEQUENCER -- requirements
Module: out_byte_sequencer

---
 rtl/out_seq_pkg.sv | 23 ++
 rtl/out_byte_sequencer_dwell_timer.sv | 37 +++
 rtl/out_byte_sequencer.sv | 128 ++++++++++++
 tb/tb_out_byte_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_seq_pkg.sv
// Shared definitions for the output byte sequencer: mode encodings, FSM states
// and the lane-index width helper.
package out_seq_pkg;

    typedef enum logic [1:0] {
        ModeStatic = 2'b00,
        ModeScan   = 2'b01,
        ModePass   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StPassRun,
        StHold
    } state_e;

    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/out_byte_sequencer_dwell_timer.sv
// Dwell counter: counts 0..dwell while enabled, pulses tc on the terminal count
// and wraps to zero; synchronous clear has priority.
module dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic [DWELL_W-1:0] count,
    output logic               tc
);

    logic [DWELL_W-1:0] count_q, count_d;

    assign count = count_q;
    assign tc    = enable && (count_q == dwell);

    always_comb begin
        count_d = count_q;
        if (clear || tc) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/out_byte_sequencer.sv
// Presents one byte lane of a captured result word on a registered output,
// statically, as a continuous scan, or as a single pass per captured word.
module out_byte_sequencer
    import out_seq_pkg::*;
#(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned DWELL_W = 16,
    localparam int unsigned NB      = DATA_W / 8,
    localparam int unsigned IDX_W   = idx_width(NB)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [1:0]         mode,
    input  logic [IDX_W-1:0]   byte_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [7:0]         byte_out,
    output logic [IDX_W-1:0]   byte_idx,
    output logic               frame_start,
    output logic               busy
);

    state_e             state_q, state_d;
    mode_e              mode_dec;
    logic [DATA_W-1:0]  shadow_q;
    logic [IDX_W-1:0]   idx_q, idx_d, byte_idx_d;
    logic [7:0]         byte_out_d;
    logic               frame_start_d;
    logic               capture, running, running_d, entering, last_lane, tc;
    logic [DWELL_W-1:0] count;

    // Out-of-range lane indices read as zero.
    function automatic logic [7:0] lane(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] k);
        lane = 8'h00;
        for (int unsigned i = 0; i < NB; i++) begin
            if (k == IDX_W'(i)) lane = w[8*i +: 8];
        end
    endfunction

    assign mode_dec   = mode_e'(mode);
    assign data_ready = (state_q != StPassRun);
    assign busy       = (state_q == StPassRun);
    assign capture    = data_valid && data_ready;
    assign running    = (state_q == StScan) || (state_q == StPassRun);
    assign running_d  = (state_d == StScan) || (state_d == StPassRun);
    assign entering   = running_d && (state_d != state_q);
    assign last_lane  = (idx_q == IDX_W'(NB - 1));

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (entering),
        .enable (running),
        .dwell  (dwell),
        .count  (count),
        .tc     (tc)
    );

    always_comb begin
        state_d = state_q;
        case (mode_dec)
            ModeStatic: state_d = StIdle;
            ModeScan:   state_d = StScan;
            ModeHold:   state_d = StHold;
            ModePass: begin
                if (state_q == StPassRun) begin
                    if (tc && last_lane) state_d = StIdle;
                end else if (capture) begin
                    state_d = StPassRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (entering) begin
            idx_d = '0;
        end else if (tc) begin
            idx_d = last_lane ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Outputs lag the internal index by one edge so byte_idx always names byte_out.
    always_comb begin
        byte_out_d    = byte_out;
        byte_idx_d    = byte_idx;
        frame_start_d = 1'b0;
        case (state_q)
            StIdle: begin
                byte_idx_d = byte_sel;
                byte_out_d = lane(shadow_q, byte_sel);
            end
            StScan, StPassRun: begin
                byte_idx_d    = idx_q;
                byte_out_d    = lane(shadow_q, idx_q);
                frame_start_d = (idx_q == '0) && (count == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            idx_q       <= '0;
            byte_out    <= 8'h00;
            byte_idx    <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            byte_out    <= byte_out_d;
            byte_idx    <= byte_idx_d;
            frame_start <= frame_start_d;
            if (capture) shadow_q <= data_in;
        end
    end

endmodule

// File: tb/tb_out_byte_sequencer.sv
// Directed bench for out_byte_sequencer at DATA_W 16, 32 and 24 with a
// scoreboard of expected lane outputs.
module tb_out_byte_sequencer;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=16
    logic [15:0] a_data_in;
    logic        a_valid, a_ready, a_fs, a_busy;
    logic [1:0]  a_mode;
    logic [0:0]  a_sel, a_idx;
    logic [15:0] a_dwell;
    logic [7:0]  a_byte;

    // Instance B: DATA_W=32
    logic [31:0] b_data_in;
    logic        b_valid, b_ready, b_fs, b_busy;
    logic [1:0]  b_mode;
    logic [1:0]  b_sel, b_idx;
    logic [15:0] b_dwell;
    logic [7:0]  b_byte;

    // Instance C: DATA_W=24
    logic [23:0] c_data_in;
    logic        c_valid, c_ready, c_fs, c_busy;
    logic [1:0]  c_mode;
    logic [1:0]  c_sel, c_idx;
    logic [15:0] c_dwell;
    logic [7:0]  c_byte;

    out_byte_sequencer #(.DATA_W(16), .DWELL_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .data_valid(a_valid),
        .data_ready(a_ready), .mode(a_mode), .byte_sel(a_sel), .dwell(a_dwell),
        .byte_out(a_byte), .byte_idx(a_idx), .frame_start(a_fs), .busy(a_busy)
    );

    out_byte_sequencer #(.DATA_W(32), .DWELL_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .data_valid(b_valid),
        .data_ready(b_ready), .mode(b_mode), .byte_sel(b_sel), .dwell(b_dwell),
        .byte_out(b_byte), .byte_idx(b_idx), .frame_start(b_fs), .busy(b_busy)
    );

    out_byte_sequencer #(.DATA_W(24), .DWELL_W(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data_in), .data_valid(c_valid),
        .data_ready(c_ready), .mode(c_mode), .byte_sel(c_sel), .dwell(c_dwell),
        .byte_out(c_byte), .byte_idx(c_idx), .frame_start(c_fs), .busy(c_busy)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [2:0] idx;
        logic       fs;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [2:0] idx, input logic fs);
        exp_t e;
        e.b   = b;
        e.idx = idx;
        e.fs  = fs;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] b, input logic [2:0] idx,
                             input logic fs);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed output %0h with no expected entry queued", tag, b);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".byte"}, 64'(b), 64'(e.b));
        cmp({tag, ".idx"}, 64'(idx), 64'(e.idx));
        cmp({tag, ".fs"}, 64'(fs), 64'(e.fs));
    endtask

    initial begin
        logic [31:0] w;
        int          ln;

        a_data_in = '0; a_valid = 1'b0; a_mode = 2'b00; a_sel = '0; a_dwell = '0;
        b_data_in = '0; b_valid = 1'b0; b_mode = 2'b00; b_sel = '0; b_dwell = '0;
        c_data_in = '0; c_valid = 1'b0; c_mode = 2'b00; c_sel = '0; c_dwell = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        cmp("rst.byte", 64'(c_byte), 64'h00);
        cmp("rst.idx", 64'(c_idx), 64'h0);
        cmp("rst.fs", 64'(c_fs), 64'h0);
        cmp("rst.busy", 64'(c_busy), 64'h0);
        cmp("rst.ready", 64'(c_ready), 64'h1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // STATIC, DATA_W=16
        a_sel = 1'b1; a_data_in = 16'hA55A; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        push(8'h00, 3'd1, 1'b0);
        pop_check("static16.pre", a_byte, {2'b00, a_idx}, a_fs);
        step();
        push(8'hA5, 3'd1, 1'b0);
        pop_check("static16.sel1", a_byte, {2'b00, a_idx}, a_fs);
        a_sel = 1'b0;
        step();
        push(8'h5A, 3'd0, 1'b0);
        pop_check("static16.sel0", a_byte, {2'b00, a_idx}, a_fs);

        // SCAN, DATA_W=32, dwell=2
        w = 32'h44332211;
        b_data_in = w; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        b_dwell = 16'd2; b_mode = 2'b01;
        step();
        for (int k = 0; k < 15; k++) begin
            ln = (k / 3) % 4;
            push(w[8*ln +: 8], 3'(ln), (k % 12) == 0);
        end
        for (int k = 0; k < 15; k++) begin
            step();
            pop_check("scan32", b_byte, {1'b0, b_idx}, b_fs);
        end

        // HOLD during SCAN: the edge that enters HOLD still advances the display once
        b_mode = 2'b11;
        step();
        ln = (15 / 3) % 4;
        push(w[8*ln +: 8], 3'(ln), 1'b0);
        pop_check("hold.enter", b_byte, {1'b0, b_idx}, b_fs);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                b_data_in = 32'hDEADBEEF; b_valid = 1'b1;
                cmp("hold.ready", 64'(b_ready), 64'h1);
            end
            step();
            b_valid = 1'b0;
            push(w[8*ln +: 8], 3'(ln), 1'b0);
            pop_check("hold.frozen", b_byte, {1'b0, b_idx}, b_fs);
        end
        b_mode = 2'b00; b_sel = 2'd0;
        step();
        push(w[8*ln +: 8], 3'(ln), 1'b0);
        pop_check("hold.leave", b_byte, {1'b0, b_idx}, b_fs);
        step();
        push(8'hEF, 3'd0, 1'b0);
        pop_check("hold.newdata", b_byte, {1'b0, b_idx}, b_fs);

        // STATIC out-of-range lane, DATA_W=24
        c_sel = 2'd3; c_data_in = 24'h123456; c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        step();
        push(8'h00, 3'd3, 1'b0);
        pop_check("static24.sel3", c_byte, {1'b0, c_idx}, c_fs);
        c_sel = 2'd2;
        step();
        push(8'h12, 3'd2, 1'b0);
        pop_check("static24.sel2", c_byte, {1'b0, c_idx}, c_fs);

        // PASS, DATA_W=24, dwell=0
        c_mode = 2'b10; c_dwell = 16'd0; c_sel = 2'd0;
        step();
        cmp("pass.wait_busy", 64'(c_busy), 64'h0);
        c_data_in = 24'hCCBBAA; c_valid = 1'b1;
        cmp("pass.wait_ready", 64'(c_ready), 64'h1);
        step();
        c_valid = 1'b0;
        cmp("pass.busy0", 64'(c_busy), 64'h1);
        cmp("pass.ready0", 64'(c_ready), 64'h0);
        push(8'hAA, 3'd0, 1'b1);
        push(8'hBB, 3'd1, 1'b0);
        push(8'hCC, 3'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            pop_check("pass24", c_byte, {1'b0, c_idx}, c_fs);
            cmp("pass.busy", 64'(c_busy), (k < 2) ? 64'h1 : 64'h0);
            cmp("pass.ready", 64'(c_ready), (k < 2) ? 64'h0 : 64'h1);
        end
        step();
        push(8'hAA, 3'd0, 1'b0);
        pop_check("pass.waiting", c_byte, {1'b0, c_idx}, c_fs);

        // Reset in the middle of a pass
        c_dwell = 16'd1; c_data_in = 24'h665544; c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        step();
        push(8'h44, 3'd0, 1'b1);
        pop_check("prerst", c_byte, {1'b0, c_idx}, c_fs);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst.byte", 64'(c_byte), 64'h00);
        cmp("midrst.idx", 64'(c_idx), 64'h0);
        cmp("midrst.fs", 64'(c_fs), 64'h0);
        cmp("midrst.busy", 64'(c_busy), 64'h0);
        cmp("midrst.ready", 64'(c_ready), 64'h1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            cmp("postrst.busy", 64'(c_busy), 64'h0);
            cmp("postrst.ready", 64'(c_ready), 64'h1);
            cmp("postrst.fs", 64'(c_fs), 64'h0);
            cmp("postrst.byte", 64'(c_byte), 64'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
